// File: rtl/burst_link_fifo.sv
// Burst-oriented link buffer between a read master and a write master:
// requests read bursts on available credit and drains stored words in fixed-size write bursts.
module burst_link_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_COUNT     = 8,
  parameter int BURST_WIDTH     = 4,
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     rd_busy,
  output logic                     rd_start,
  input  logic                     wr_busy,
  input  logic                     wr_ready,
  output logic                     wr_start,
  output logic                     wr_valid,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [FIFO_DEPTH_LOG2:0] level,
  output logic                     overflow
);

  localparam int LW = FIFO_DEPTH_LOG2 + 1;
  localparam int CW = FIFO_DEPTH_LOG2 + 3;
  localparam logic [LW-1:0]          DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]          BURST_L = LW'(BURST_COUNT);
  localparam logic [CW-1:0]          DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]          BURST_C = CW'(BURST_COUNT);
  localparam logic [BURST_WIDTH-1:0] BEATS_L = BURST_WIDTH'(BURST_COUNT);

  typedef enum logic [1:0] {W_IDLE, W_START, W_STREAM} wstate_t;

  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]              pending, pending_dec;
  logic [BURST_WIDTH-1:0]     beat_cnt, beat_next;
  wstate_t                    state, state_next;
  logic                       push, pop, rd_fire, credit_ok;

  // Handshake: a word moves to the write master on any cycle where wr_valid and
  // wr_ready are both high; wr_data is stable while wr_valid=1 and wr_ready=0.
  assign push     = in_valid && (level != DEPTH_L);
  assign wr_valid = (state == W_STREAM);
  assign wr_start = (state == W_START);
  assign pop      = wr_valid && wr_ready;
  assign wr_data  = wr_valid ? mem[rd_ptr] : '0;

  // credit = depth - level - pending, compared without risk of going negative
  assign credit_ok   = (CW'(level) + CW'(pending) + BURST_C) <= DEPTH_C;
  assign rd_fire     = !rd_busy && !rd_start && credit_ok;
  assign pending_dec = (push && pending != '0) ? pending - 1'b1 : pending;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pending  <= '0;
      rd_start <= 1'b0;
      overflow <= 1'b0;
      state    <= W_IDLE;
      beat_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (in_valid && !push) overflow <= 1'b1;
      pending  <= pending_dec + (rd_fire ? BURST_L : '0);
      rd_start <= rd_fire;
      state    <= state_next;
      beat_cnt <= beat_next;
    end
  end

  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    case (state)
      W_IDLE: begin
        if (level >= BURST_L && !wr_busy) state_next = W_START;
      end
      W_START: begin
        beat_next  = BEATS_L;
        state_next = W_STREAM;
      end
      W_STREAM: begin
        if (pop) begin
          beat_next = beat_cnt - 1'b1;
          if (beat_cnt == BURST_WIDTH'(1)) state_next = W_IDLE;
        end
      end
      default: state_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_burst_link_fifo.sv
// Randomised bench for burst_link_fifo, checked every cycle against a queue-based
// reference model of storage, credit and burst behaviour.
module tb_burst_link_fifo;

  localparam int DW    = 32;
  localparam int BURST = 8;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, rd_busy, wr_busy, wr_ready;
  logic [DW-1:0] in_data;
  logic          rd_start, wr_start, wr_valid, overflow;
  logic [DW-1:0] wr_data;
  logic [5:0]    level;

  burst_link_fifo dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .rd_busy(rd_busy), .rd_start(rd_start), .wr_busy(wr_busy),
    .wr_ready(wr_ready), .wr_start(wr_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: stored words, outstanding credit, burst phase (0 idle, 1 start, 2 stream)
  logic [DW-1:0] exp_q[$];
  int m_pending = 0;
  bit m_ovf = 1'b0;
  bit m_rd  = 1'b0;
  int m_phase = 0;
  int m_rem = 0;
  int m_pops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit iv, input logic [DW-1:0] d,
                            input bit rb, input bit wb, input bit wrdy);
    int  size;
    bit  push, pop, fire;
    if (rst) begin
      exp_q.delete();
      m_pending = 0; m_ovf = 0; m_rd = 0; m_phase = 0; m_rem = 0;
      return;
    end
    size = exp_q.size();
    push = iv && (size < DEPTH);
    if (iv && !push) m_ovf = 1'b1;
    pop  = (m_phase == 2) && wrdy;
    fire = !rb && !m_rd && (DEPTH - size - m_pending >= BURST);
    if (pop) begin
      void'(exp_q.pop_front());
      m_pops++;
    end
    if (push) exp_q.push_back(d);
    if (push && m_pending > 0) m_pending--;
    if (fire) m_pending += BURST;
    m_rd = fire;
    case (m_phase)
      0: if (size >= BURST && !wb) m_phase = 1;
      1: begin m_phase = 2; m_rem = BURST; end
      default: if (pop) begin
        m_rem--;
        if (m_rem == 0) m_phase = 0;
      end
    endcase
  endtask

  task automatic cycle(input bit rst, input bit iv, input logic [DW-1:0] d,
                       input bit rb, input bit wb, input bit wrdy);
    logic [DW-1:0] exp_data;
    @(negedge clk);
    exp_data = (m_phase == 2 && exp_q.size() > 0) ? exp_q[0] : '0;
    check("rd_start", 32'(rd_start), 32'(m_rd));
    check("wr_start", 32'(wr_start), 32'(m_phase == 1));
    check("wr_valid", 32'(wr_valid), 32'(m_phase == 2));
    check("wr_data",  wr_data, exp_data);
    check("level",    32'(level), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    reset = rst; in_valid = iv; in_data = d;
    rd_busy = rb; wr_busy = wb; wr_ready = wrdy;
    model_step(rst, iv, d, rb, wb, wrdy);
    @(posedge clk);
  endtask

  initial begin
    int start_pops;
    int guard;
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    rd_busy = 1'b0; wr_busy = 1'b0; wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    cycle(1, 0, 0, 0, 0, 0);

    // read requests after reset release: pulses every other cycle until credit runs out
    repeat (10) cycle(0, 0, 0, 0, 1, 0);
    check("rd_idle_no_credit", 32'(rd_start), 32'd0);

    // one full burst with wr_ready held high
    for (int i = 1; i <= 8; i++) cycle(0, 1, i, 0, 0, 1);
    repeat (12) cycle(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("drained_level", 32'(level), 32'd0);

    // burst with wr_ready toggling
    for (int i = 1; i <= 8; i++) cycle(0, 1, 32'h100 + i, 0, 0, i[0]);
    for (int i = 0; i < 24; i++) cycle(0, 0, 0, 0, 0, i[0]);

    // fill to full with writes blocked, then overrun
    for (int i = 0; i < 34; i++) cycle(0, 1, 32'h200 + i, 0, 1, 0);
    @(negedge clk);
    check("full_level", 32'(level), 32'd32);
    check("full_overflow", 32'(overflow), 32'd1);
    repeat (4) cycle(0, 0, 0, 0, 1, 0);

    // reset three beats into a burst
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 32'h300 + i, 0, 1, 0);
    start_pops = m_pops;
    guard = 0;
    while (m_pops - start_pops < 3 && guard < 40) begin
      cycle(0, 0, 0, 0, 0, 1);
      guard++;
    end
    check("burst3_reached", 32'(m_pops - start_pops), 32'd3);
    cycle(1, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // concurrent push and pop around level 10 across the pointer wrap
    for (int i = 0; i < 10; i++) cycle(0, 1, 32'h400 + i, 1, 1, 0);
    for (int i = 0; i < 40; i++) cycle(0, 1, 32'h500 + i, 1, 0, 1);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 499) == 0,
            $urandom_range(0, 9) < 7,
            $urandom,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
